csr_unit: RTL



---
 rtl/csr_unit.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/csr_unit.sv
// Machine/supervisor CSR file for the RV32 core: combinational reads, trap entry/return and CSR writes.
// Optional 64-bit cycle counter and instret views are built when RAFI_CSR_COUNTERS_EN is defined.
module csr_unit (
    input  logic        clk,
    input  logic        rstN,
    input  logic [11:0] readAddr,
    input  logic        readEnable,
    input  logic [63:0] readOpId,
    output logic [31:0] readValue,
    output logic        readIllegal,
    input  logic [31:0] writeValue,
    input  logic [11:0] writeAddr,
    input  logic        writeEnable,
    input  logic        trapValid,
    input  logic [31:0] trapCause,
    input  logic [31:0] trapValue,
    input  logic [31:0] trapPc,
    input  logic        trapReturn,
    input  logic [1:0]  trapReturnPrivilege,
    output logic [31:0] nextPc,
    output logic [31:0] satp,
    output logic [31:0] mstatus,
    output logic [1:0]  privilege,
    output logic        trapSupervisorReturn
);

    localparam logic [31:0] MSTATUS_MASK = 32'h007C_19AA;
    localparam logic [31:0] SSTATUS_MASK = 32'h000C_0122;
    localparam logic [31:0] MISA_VALUE   = 32'h4014_1101;

    logic [31:0] medeleg, mie, mtvec, mscratch, mepc, mcause, mtval;
    logic [31:0] stvec, sscratch, sepc, scause, stval;

`ifdef RAFI_CSR_COUNTERS_EN
    logic [63:0] mcycle;
`else
    logic unusedOpId;
    assign unusedOpId = ^readOpId;
`endif

    logic [31:0] readData;
    logic        readHit;

    always_comb begin
        readHit  = 1'b1;
        readData = 32'd0;
        case (readAddr)
            12'h300: readData = mstatus;
            12'h301: readData = MISA_VALUE;
            12'h302: readData = medeleg;
            12'h304: readData = mie;
            12'h305: readData = mtvec;
            12'h340: readData = mscratch;
            12'h341: readData = mepc;
            12'h342: readData = mcause;
            12'h343: readData = mtval;
            12'h100: readData = mstatus & SSTATUS_MASK;
            12'h105: readData = stvec;
            12'h140: readData = sscratch;
            12'h141: readData = sepc;
            12'h142: readData = scause;
            12'h143: readData = stval;
            12'h180: readData = satp;
`ifdef RAFI_CSR_COUNTERS_EN
            12'hB00, 12'hC00: readData = mcycle[31:0];
            12'hB80, 12'hC80: readData = mcycle[63:32];
            12'hB02, 12'hC02: readData = readOpId[31:0];
            12'hB82, 12'hC82: readData = readOpId[63:32];
`endif
            default: readHit = 1'b0;
        endcase
        readIllegal = readEnable & (~readHit | (readAddr[9:8] > privilege));
        readValue   = readIllegal ? 32'd0 : readData;
    end

    logic        delegate;
    logic        isMret;
    logic [31:0] tvec;
    logic [31:0] mstatusTrapM, mstatusTrapS, mstatusMret, mstatusSret;
    logic [31:0] mstatusWrite, sstatusWrite;

    // Only exception codes below 32 can be delegated; medeleg has no bits beyond that.
    always_comb begin
        delegate = (privilege <= 2'd1) && !trapCause[31] && (trapCause[30:5] == 26'd0)
                   && medeleg[trapCause[4:0]];
        isMret   = (trapReturnPrivilege == 2'd3);
        tvec     = delegate ? stvec : mtvec;

        nextPc = 32'd0;
        if (trapValid) begin
            nextPc = {tvec[31:2], 2'b00};
            if (tvec[1:0] == 2'b01 && trapCause[31])
                nextPc = nextPc + {trapCause[29:0], 2'b00};
        end else if (trapReturn) begin
            nextPc = isMret ? mepc : sepc;
        end

        mstatusTrapM         = mstatus;
        mstatusTrapM[7]      = mstatus[3];
        mstatusTrapM[3]      = 1'b0;
        mstatusTrapM[12:11]  = privilege;

        mstatusTrapS         = mstatus;
        mstatusTrapS[5]      = mstatus[1];
        mstatusTrapS[1]      = 1'b0;
        mstatusTrapS[8]      = privilege[0];

        mstatusMret          = mstatus;
        mstatusMret[3]       = mstatus[7];
        mstatusMret[7]       = 1'b1;
        mstatusMret[12:11]   = 2'b00;

        mstatusSret          = mstatus;
        mstatusSret[1]       = mstatus[5];
        mstatusSret[5]       = 1'b1;
        mstatusSret[8]       = 1'b0;

        mstatusWrite = writeValue & MSTATUS_MASK;
        if (mstatusWrite[12:11] == 2'b10)
            mstatusWrite[12:11] = 2'b00;
        sstatusWrite = (mstatus & ~SSTATUS_MASK) | (writeValue & SSTATUS_MASK);
    end

    assign trapSupervisorReturn = mstatus[22];

    always_ff @(posedge clk) begin
        if (!rstN) begin
            privilege <= 2'd3;
            mstatus   <= 32'd0;
            satp      <= 32'd0;
            medeleg   <= 32'd0;
            mie       <= 32'd0;
            mtvec     <= 32'd0;
            mscratch  <= 32'd0;
            mepc      <= 32'd0;
            mcause    <= 32'd0;
            mtval     <= 32'd0;
            stvec     <= 32'd0;
            sscratch  <= 32'd0;
            sepc      <= 32'd0;
            scause    <= 32'd0;
            stval     <= 32'd0;
`ifdef RAFI_CSR_COUNTERS_EN
            mcycle    <= 64'd0;
`endif
        end else begin
`ifdef RAFI_CSR_COUNTERS_EN
            mcycle <= mcycle + 64'd1;
`endif
            if (trapValid) begin
                if (delegate) begin
                    sepc      <= trapPc;
                    scause    <= trapCause;
                    stval     <= trapValue;
                    mstatus   <= mstatusTrapS;
                    privilege <= 2'd1;
                end else begin
                    mepc      <= trapPc;
                    mcause    <= trapCause;
                    mtval     <= trapValue;
                    mstatus   <= mstatusTrapM;
                    privilege <= 2'd3;
                end
            end else if (trapReturn) begin
                if (isMret) begin
                    privilege <= mstatus[12:11];
                    mstatus   <= mstatusMret;
                end else begin
                    privilege <= {1'b0, mstatus[8]};
                    mstatus   <= mstatusSret;
                end
            end else if (writeEnable) begin
                case (writeAddr)
                    12'h300: mstatus  <= mstatusWrite;
                    12'h302: medeleg  <= writeValue;
                    12'h304: mie      <= writeValue;
                    12'h305: mtvec    <= writeValue;
                    12'h340: mscratch <= writeValue;
                    12'h341: mepc     <= {writeValue[31:2], 2'b00};
                    12'h342: mcause   <= writeValue;
                    12'h343: mtval    <= writeValue;
                    12'h100: mstatus  <= sstatusWrite;
                    12'h105: stvec    <= writeValue;
                    12'h140: sscratch <= writeValue;
                    12'h141: sepc     <= {writeValue[31:2], 2'b00};
                    12'h142: scause   <= writeValue;
                    12'h143: stval    <= writeValue;
                    12'h180: satp     <= writeValue;
`ifdef RAFI_CSR_COUNTERS_EN
                    // A counter write replaces the whole half and overrides this cycle's increment.
                    12'hB00: mcycle   <= {mcycle[63:32], writeValue};
                    12'hB80: mcycle   <= {writeValue, mcycle[31:0]};
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule
